// File: rtl/msrh_freelist_pkg.sv
// Core-wide configuration shared by the rename-stage free lists.
// msrh_conf_pkg holds build knobs; msrh_pkg derives widths from them.
package msrh_conf_pkg;
    localparam int RV_BRU_ENTRY_SIZE = 4;
    localparam int DISP_SIZE         = 2;
endpackage

package msrh_pkg;
    localparam int FLIST_SIZE = 32;
    // IDs 0..31 are architectural; each dispatch lane owns FLIST_SIZE more.
    localparam int RNID_W =
        $clog2(32 + msrh_conf_pkg::DISP_SIZE * FLIST_SIZE);
endpackage

// File: rtl/msrh_freelist_if.sv
// Rename <-> free-list bundle: push/pop of RNIDs plus branch snapshots.
// master = rename stage, slave = free list.
interface msrh_freelist_if #(
    parameter int SIZE    = msrh_pkg::FLIST_SIZE,
    parameter int WIDTH   = msrh_pkg::RNID_W,
    parameter int BR_TAGS = msrh_conf_pkg::RV_BRU_ENTRY_SIZE
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam int TW = $clog2(BR_TAGS);

    logic             i_push;
    logic [WIDTH-1:0] i_push_id;
    logic             i_pop;
    logic [WIDTH-1:0] o_pop_id;
    logic             o_is_empty;
    logic [CW-1:0]    o_count;
    logic             i_br_snap_valid;
    logic [TW-1:0]    i_br_snap_tag;
    logic             i_br_restore;
    logic [TW-1:0]    i_br_restore_tag;

    modport master (
        output i_push, i_push_id, i_pop,
        output i_br_snap_valid, i_br_snap_tag,
        output i_br_restore, i_br_restore_tag,
        input  o_pop_id, o_is_empty, o_count
    );

    modport slave (
        input  i_push, i_push_id, i_pop,
        input  i_br_snap_valid, i_br_snap_tag,
        input  i_br_restore, i_br_restore_tag,
        output o_pop_id, o_is_empty, o_count
    );
endinterface

// File: rtl/msrh_freelist.sv
// Circular free list of physical-register IDs with per-branch head
// snapshots so a mispredict can hand back everything renamed since.
module msrh_freelist #(
    parameter int SIZE    = msrh_pkg::FLIST_SIZE,
    parameter int WIDTH   = msrh_pkg::RNID_W,
    parameter int INIT    = 0,
    parameter int BR_TAGS = msrh_conf_pkg::RV_BRU_ENTRY_SIZE
) (
    input logic            i_clk,
    input logic            i_reset,
    msrh_freelist_if.slave fl
);
    localparam int AW = $clog2(SIZE);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem  [SIZE];
    logic [PW-1:0]    snap [BR_TAGS];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_nxt;

    // Restore overrides the pop; snapshots capture this same value.
    always_comb begin
        head_nxt = head + PW'(fl.i_pop);
        if (fl.i_br_restore) begin
            head_nxt = snap[fl.i_br_restore_tag];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head <= '0;
            tail <= PW'(SIZE);
            for (int k = 0; k < SIZE; k++) begin
                mem[k] <= WIDTH'(INIT + k);
            end
            for (int t = 0; t < BR_TAGS; t++) begin
                snap[t] <= '0;
            end
        end else begin
            head <= head_nxt;
            if (fl.i_push) begin
                mem[tail[AW-1:0]] <= fl.i_push_id;
                tail              <= tail + PW'(1);
            end
            if (fl.i_br_snap_valid) begin
                snap[fl.i_br_snap_tag] <= head_nxt;
            end
        end
    end

    assign fl.o_pop_id   = mem[head[AW-1:0]];
    assign fl.o_count    = tail - head;
    assign fl.o_is_empty = (head == tail);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(fl.i_push && !fl.i_pop &&
                      fl.o_count == PW'(SIZE)));
        end
    end
endmodule

// File: tb/tb_msrh_freelist.sv
// Directed bench for msrh_freelist: an unbounded-sequence model is
// compared every cycle, plus literal checks of hand-worked scenarios.
module tb_msrh_freelist;
    localparam int SIZE    = 32;
    localparam int INIT    = 32;
    localparam int BR_TAGS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msrh_freelist_if #(
        .SIZE(SIZE), .WIDTH(msrh_pkg::RNID_W), .BR_TAGS(BR_TAGS)
    ) fl_if ();

    msrh_freelist #(
        .SIZE(SIZE), .WIDTH(msrh_pkg::RNID_W),
        .INIT(INIT), .BR_TAGS(BR_TAGS)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .fl     (fl_if)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: every ID ever queued in order; h counts IDs consumed.
    int seq[$];
    int h = 0;
    int snap_m[BR_TAGS];
    bit armed = 1'b0;

    function automatic void chk(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        int n;
        if (armed) begin
            n = seq.size() - h;
            chk("model_count", int'(fl_if.o_count), n);
            chk("model_empty", int'(fl_if.o_is_empty), int'(n == 0));
            if (n > 0) chk("model_pop_id", int'(fl_if.o_pop_id), seq[h]);
        end
    end

    task automatic idle_inputs();
        fl_if.i_push           = 1'b0;
        fl_if.i_push_id        = '0;
        fl_if.i_pop            = 1'b0;
        fl_if.i_br_snap_valid  = 1'b0;
        fl_if.i_br_snap_tag    = '0;
        fl_if.i_br_restore     = 1'b0;
        fl_if.i_br_restore_tag = '0;
        rst                    = 1'b0;
    endtask

    task automatic tick();
        bit ps, pp, sv, rs, rr;
        int pid, st, rt, hn;
        ps  = fl_if.i_push;
        pid = int'(fl_if.i_push_id);
        pp  = fl_if.i_pop;
        sv  = fl_if.i_br_snap_valid;
        st  = int'(fl_if.i_br_snap_tag);
        rs  = fl_if.i_br_restore;
        rt  = int'(fl_if.i_br_restore_tag);
        rr  = rst;
        @(posedge clk);
        if (rr) begin
            seq.delete();
            for (int k = 0; k < SIZE; k++) seq.push_back(INIT + k);
            h = 0;
            for (int t = 0; t < BR_TAGS; t++) snap_m[t] = 0;
            armed = 1'b1;
        end else begin
            hn = rs ? snap_m[rt] : h + int'(pp);
            if (sv) snap_m[st] = hn;
            if (ps) seq.push_back(pid);
            h = hn;
        end
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            fl_if.i_pop = 1'b1;
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        chk("rst_count", int'(fl_if.o_count), 32);
        chk("rst_empty", int'(fl_if.o_is_empty), 0);
        chk("rst_pop_id", int'(fl_if.o_pop_id), 32);

        // Three pops from reset
        pop_n(1);
        chk("pop1_id", int'(fl_if.o_pop_id), 33);
        pop_n(1);
        chk("pop2_id", int'(fl_if.o_pop_id), 34);
        pop_n(1);
        chk("pop3_count", int'(fl_if.o_count), 29);

        // Drain to empty, then refill one
        pop_n(29);
        chk("drain_empty", int'(fl_if.o_is_empty), 1);
        chk("drain_count", int'(fl_if.o_count), 0);
        fl_if.i_push    = 1'b1;
        fl_if.i_push_id = 7'd5;
        tick();
        chk("refill_empty", int'(fl_if.o_is_empty), 0);
        chk("refill_id", int'(fl_if.o_pop_id), 5);
        fl_if.i_push    = 1'b1;
        fl_if.i_push_id = 7'd6;
        fl_if.i_pop     = 1'b1;
        tick();
        chk("pushpop1_id", int'(fl_if.o_pop_id), 6);
        chk("pushpop1_count", int'(fl_if.o_count), 1);

        // Snapshot with same-cycle pop, then restore
        do_reset();
        pop_n(2);
        fl_if.i_pop           = 1'b1;
        fl_if.i_br_snap_valid = 1'b1;
        fl_if.i_br_snap_tag   = 2'd1;
        tick();
        pop_n(3);
        fl_if.i_br_restore     = 1'b1;
        fl_if.i_br_restore_tag = 2'd1;
        tick();
        chk("restore_id", int'(fl_if.o_pop_id), 35);
        chk("restore_count", int'(fl_if.o_count), 29);

        // Restore and snapshot together: snapshot takes restored head
        do_reset();
        pop_n(1);
        fl_if.i_br_snap_valid = 1'b1;
        fl_if.i_br_snap_tag   = 2'd1;
        tick();
        pop_n(3);
        fl_if.i_br_restore     = 1'b1;
        fl_if.i_br_restore_tag = 2'd1;
        fl_if.i_br_snap_valid  = 1'b1;
        fl_if.i_br_snap_tag    = 2'd0;
        fl_if.i_pop            = 1'b1;
        tick();
        chk("rs_snap_id", int'(fl_if.o_pop_id), 33);
        pop_n(2);
        fl_if.i_br_restore     = 1'b1;
        fl_if.i_br_restore_tag = 2'd0;
        tick();
        chk("rs_snap_id2", int'(fl_if.o_pop_id), 33);
        chk("rs_snap_count", int'(fl_if.o_count), 31);

        // Push + pop while full
        do_reset();
        chk("full_pp_id_now", int'(fl_if.o_pop_id), 32);
        fl_if.i_push    = 1'b1;
        fl_if.i_push_id = 7'd7;
        fl_if.i_pop     = 1'b1;
        tick();
        chk("full_pp_count", int'(fl_if.o_count), 32);
        chk("full_pp_next_id", int'(fl_if.o_pop_id), 33);
        pop_n(30);
        chk("full_pp_id63", int'(fl_if.o_pop_id), 63);
        pop_n(1);
        chk("full_pp_id7", int'(fl_if.o_pop_id), 7);
        chk("full_pp_count1", int'(fl_if.o_count), 1);

        // Restore with push and ignored pop
        do_reset();
        pop_n(2);
        fl_if.i_br_snap_valid = 1'b1;
        fl_if.i_br_snap_tag   = 2'd2;
        tick();
        pop_n(4);
        chk("pre_rpp_count", int'(fl_if.o_count), 26);
        fl_if.i_br_restore     = 1'b1;
        fl_if.i_br_restore_tag = 2'd2;
        fl_if.i_push           = 1'b1;
        fl_if.i_push_id        = 7'd9;
        fl_if.i_pop            = 1'b1;
        tick();
        chk("rpp_count", int'(fl_if.o_count), 31);
        chk("rpp_id", int'(fl_if.o_pop_id), 34);
        pop_n(30);
        chk("rpp_id9", int'(fl_if.o_pop_id), 9);

        // Reset beats everything and clears snapshots
        rst                    = 1'b1;
        fl_if.i_pop            = 1'b1;
        fl_if.i_push           = 1'b1;
        fl_if.i_push_id        = 7'd44;
        fl_if.i_br_snap_valid  = 1'b1;
        fl_if.i_br_snap_tag    = 2'd2;
        fl_if.i_br_restore     = 1'b1;
        fl_if.i_br_restore_tag = 2'd3;
        tick();
        chk("rstprio_count", int'(fl_if.o_count), 32);
        chk("rstprio_id", int'(fl_if.o_pop_id), 32);
        pop_n(5);
        fl_if.i_br_restore     = 1'b1;
        fl_if.i_br_restore_tag = 2'd2;
        tick();
        chk("snap_clr_id", int'(fl_if.o_pop_id), 32);
        chk("snap_clr_count", int'(fl_if.o_count), 32);

        // Reset after mixed traffic
        pop_n(10);
        fl_if.i_push    = 1'b1;
        fl_if.i_push_id = 7'd100;
        tick();
        fl_if.i_push    = 1'b1;
        fl_if.i_push_id = 7'd101;
        tick();
        chk("mixed_count", int'(fl_if.o_count), 24);
        do_reset();
        chk("rst2_count", int'(fl_if.o_count), 32);
        chk("rst2_id", int'(fl_if.o_pop_id), 32);

        // Steady push+pop at full across several pointer wraps
        for (int i = 0; i < 70; i++) begin
            fl_if.i_push    = 1'b1;
            fl_if.i_push_id = 7'(i + 1);
            fl_if.i_pop     = 1'b1;
            tick();
        end
        chk("wrap_count", int'(fl_if.o_count), 32);
        chk("wrap_id", int'(fl_if.o_pop_id), 39);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
